// File: rtl/vga_sync_to_count.sv
// Receive-side VGA timing recovery. Rebuilds column/row counters from an active-high
// HSync/VSync pair, checks them against the frame geometry and reports lock.
module vga_sync_to_count #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_HSync,
  input  logic                          i_VSync,
  output logic                          o_HSync,
  output logic                          o_VSync,
  output logic [$clog2(TOTAL_COLS)-1:0] o_Col_Count,
  output logic [$clog2(TOTAL_ROWS)-1:0] o_Row_Count,
  output logic                          o_Locked,
  output logic                          o_Sync_Err,
  output logic                          o_Frame_Start
);

  localparam int CW = $clog2(TOTAL_COLS);
  localparam int RW = $clog2(TOTAL_ROWS);
  localparam logic [CW-1:0] COL_LAST = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(TOTAL_ROWS - 1);

  // The active sizes only document the geometry; reject impossible combinations.
  if (ACTIVE_COLS >= TOTAL_COLS || ACTIVE_ROWS >= TOTAL_ROWS) begin : g_bad_geometry
    $error("vga_sync_to_count: active region must be smaller than the total frame");
  end

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic          hs_q, hs_d, hs_dly_q, hs_dly_d;
  logic          vs_q, vs_d, vs_dly_q, vs_dly_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  state_t        state_q, state_d;
  logic          clean_q, clean_d;
  logic          locked_q, locked_d;
  logic          sync_err_q, sync_err_d;
  logic          frame_start_q, frame_start_d;
  logic          h_edge, v_edge;
  logic          col_err, row_err, timing_err;

  always_comb begin
    hs_d     = i_HSync;
    vs_d     = i_VSync;
    hs_dly_d = hs_q;
    vs_dly_d = vs_q;
    h_edge   = hs_q & ~hs_dly_q;
    v_edge   = vs_q & ~vs_dly_q;

    // Counters always follow the observed edges, even when the timing is wrong.
    if (h_edge || col_q == COL_LAST) col_d = '0;
    else                             col_d = col_q + 1'b1;

    if (v_edge)                row_d = '0;
    else if (h_edge)           row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    else                       row_d = row_q;

    frame_start_d = v_edge;

    col_err = (h_edge && col_q != COL_LAST) || (col_q == COL_LAST && !h_edge);
    row_err = (v_edge && !(row_q == ROW_LAST && h_edge)) ||
              (row_q == ROW_LAST && h_edge && !v_edge);
    timing_err = col_err | row_err;
  end

  // Lock tracking: a frame boundary only counts once a full frame since the
  // previous boundary (or since entering ALIGN) has gone by without errors.
  always_comb begin
    state_d    = state_q;
    clean_d    = clean_q;
    sync_err_d = 1'b0;
    case (state_q)
      SEARCH: begin
        if (v_edge) begin
          state_d = ALIGN;
          clean_d = 1'b1;
        end
      end
      ALIGN: begin
        if (timing_err) begin
          sync_err_d = 1'b1;
          clean_d    = 1'b0;
        end else if (v_edge) begin
          if (clean_q) state_d = LOCKED;
          clean_d = 1'b1;
        end
      end
      LOCKED: begin
        if (timing_err) begin
          state_d    = ALIGN;
          sync_err_d = 1'b1;
          clean_d    = 1'b0;
        end
      end
      default: begin
        state_d = SEARCH;
        clean_d = 1'b0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs_q          <= 1'b0;
      hs_dly_q      <= 1'b0;
      vs_q          <= 1'b0;
      vs_dly_q      <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      state_q       <= SEARCH;
      clean_q       <= 1'b0;
      locked_q      <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      hs_dly_q      <= hs_dly_d;
      vs_q          <= vs_d;
      vs_dly_q      <= vs_dly_d;
      col_q         <= col_d;
      row_q         <= row_d;
      state_q       <= state_d;
      clean_q       <= clean_d;
      locked_q      <= locked_d;
      sync_err_q    <= sync_err_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_HSync       = hs_dly_q;
  assign o_VSync       = vs_dly_q;
  assign o_Col_Count   = col_q;
  assign o_Row_Count   = row_q;
  assign o_Locked      = locked_q;
  assign o_Sync_Err    = sync_err_q;
  assign o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_to_count.sv
// Scoreboard bench for vga_sync_to_count on a 10x6 frame: ideal frames, a short line,
// a dropped HSync line, an early VSync and a mid-frame reset.
module tb_vga_sync_to_count;

  localparam int TC = 10;
  localparam int TR = 6;
  localparam int AC = 8;
  localparam int AR = 4;
  localparam int CW = $clog2(TC);
  localparam int RW = $clog2(TR);

  logic          clk  = 1'b0;
  logic          rstN = 1'b1;
  logic          hsIn = 1'b0;
  logic          vsIn = 1'b0;
  logic          hsOut, vsOut, lockedOut, syncErrOut, frameStartOut;
  logic [CW-1:0] colOut;
  logic [RW-1:0] rowOut;

  vga_sync_to_count #(
    .TOTAL_COLS (TC),
    .TOTAL_ROWS (TR),
    .ACTIVE_COLS(AC),
    .ACTIVE_ROWS(AR)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rstN),
    .i_HSync      (hsIn),
    .i_VSync      (vsIn),
    .o_HSync      (hsOut),
    .o_VSync      (vsOut),
    .o_Col_Count  (colOut),
    .o_Row_Count  (rowOut),
    .o_Locked     (lockedOut),
    .o_Sync_Err   (syncErrOut),
    .o_Frame_Start(frameStartOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic hs;
    logic vs;
    logic fs;
    logic err;
    logic locked;
    logic cntValid;
    int   col;
    int   row;
  } expT;

  expT expQ[$];
  int  checkCount = 0;
  int  failCount  = 0;
  int  gFrame     = 0;
  int  lockAt     = 1;
  bit  expLocked  = 1'b0;
  bit  cntValid   = 1'b1;
  bit  inReset    = 1'b0;
  bit  pendingStartErr = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s frame=%0d actual=%0d expected=%0d t=%0t", tag, gFrame, actual, expected, $time);
    end
  endtask

  // Outputs are compared on the falling edge against the entry pushed two cycles earlier.
  task automatic applyStimulus(input logic hs, input logic vs, input expT e);
    expT x;
    @(negedge clk);
    if (!inReset && expQ.size() >= 2) begin
      x = expQ.pop_front();
      checkOutput("o_HSync", hsOut, x.hs);
      checkOutput("o_VSync", vsOut, x.vs);
      checkOutput("o_Frame_Start", frameStartOut, x.fs);
      checkOutput("o_Sync_Err", syncErrOut, x.err);
      checkOutput("o_Locked", lockedOut, x.locked);
      if (x.cntValid) begin
        checkOutput("o_Col_Count", colOut, x.col);
        checkOutput("o_Row_Count", rowOut, x.row);
      end
    end
    hsIn = hs;
    vsIn = vs;
    if (!inReset) expQ.push_back(e);
  endtask

  task automatic assertReset();
    #2 rstN = 1'b0;
    #1;
    checkOutput("rst o_HSync", hsOut, 0);
    checkOutput("rst o_VSync", vsOut, 0);
    checkOutput("rst o_Col_Count", colOut, 0);
    checkOutput("rst o_Row_Count", rowOut, 0);
    checkOutput("rst o_Locked", lockedOut, 0);
    checkOutput("rst o_Sync_Err", syncErrOut, 0);
    checkOutput("rst o_Frame_Start", frameStartOut, 0);
    expQ.delete();
    inReset   = 1'b1;
    cntValid  = 1'b0;
    expLocked = 1'b0;
    lockAt    = gFrame + 2;
  endtask

  // One generator frame with optional faults; -1 disables a fault.
  task automatic runFrame(input int shortRow, input int dropRow, input int earlyRow, input int rstRow);
    expT e;
    bit  errNow;
    int  lineLen;
    for (int r = 0; r < TR; r++) begin
      lineLen = (r == shortRow) ? TC - 1 : TC;
      for (int c = 0; c < lineLen; c++) begin
        if (r == rstRow && c == 3) assertReset();
        if (rstRow >= 0 && r == rstRow + 1 && c == 0) begin
          rstN    = 1'b1;
          inReset = 1'b0;
        end
        errNow = (shortRow >= 0 && r == shortRow + 1 && c == 0) ||
                 (r == dropRow && c == 0) ||
                 (r == 0 && c == 0 && pendingStartErr);
        if (r == 0 && c == 0) begin
          cntValid = 1'b1;
          if (gFrame == lockAt) expLocked = 1'b1;
        end
        if (errNow) expLocked = 1'b0;
        e.hs       = (c < AC) && (r != dropRow);
        e.vs       = (r < AR) && (r != earlyRow);
        e.fs       = (r == 0 && c == 0);
        e.err      = errNow;
        e.locked   = expLocked;
        e.cntValid = cntValid;
        e.col      = c;
        e.row      = (dropRow >= 0 && r >= dropRow) ? r - 1 : r;
        applyStimulus(e.hs, e.vs, e);
      end
      if (r == earlyRow) break;
    end
    pendingStartErr = (dropRow >= 0) || (earlyRow >= 0);
    gFrame++;
  endtask

  initial begin
    #1 rstN = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("init o_HSync", hsOut, 0);
    checkOutput("init o_VSync", vsOut, 0);
    checkOutput("init o_Col_Count", colOut, 0);
    checkOutput("init o_Row_Count", rowOut, 0);
    checkOutput("init o_Locked", lockedOut, 0);
    checkOutput("init o_Sync_Err", syncErrOut, 0);
    checkOutput("init o_Frame_Start", frameStartOut, 0);
    rstN = 1'b1;

    for (int f = 0; f < 3; f++) runFrame(-1, -1, -1, -1);
    // Short line in frame 3: relock needs frame 4 clean, so lock returns at frame 5.
    lockAt = 5;
    runFrame(1, -1, -1, -1);
    for (int f = 0; f < 2; f++) runFrame(-1, -1, -1, -1);
    // Lost HSync line leaves the row one behind, so frame 7 start also errors.
    lockAt = 9;
    runFrame(-1, 2, -1, -1);
    for (int f = 0; f < 3; f++) runFrame(-1, -1, -1, -1);
    // VSync rises again at row 4: the restarted frame 11 start is an error.
    lockAt = 13;
    runFrame(-1, -1, 3, -1);
    for (int f = 0; f < 3; f++) runFrame(-1, -1, -1, -1);
    runFrame(-1, -1, -1, 4);
    for (int f = 0; f < 2; f++) runFrame(-1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checkCount);
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule

// File: doc/vga_sync_to_count.md
# vga_sync_to_count

Receive-side companion to the VGA sync pulse generator. It takes the active-high HSync/VSync pair (high while column/row is inside the active region) and regenerates matching column/row counters. It checks the incoming timing against the configured frame geometry and reports lock status. It sits at the input of any downstream pixel-processing stage that needs the counts re-derived from the sync pair alone.

## Interface
- TOTAL_COLS, 800, clocks per line.
- TOTAL_ROWS, 525, lines per frame.
- ACTIVE_COLS, 640, active columns; used only for documentation and bench checks, not by the logic.
- ACTIVE_ROWS, 480, active rows; used only for documentation and bench checks, not by the logic.
- i_Clk  in  1  pixel clock, 25 MHz for 640x480.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_HSync  in  1  high while column < ACTIVE_COLS.
- i_VSync  in  1  high while row < ACTIVE_ROWS.
- o_HSync  out  1  i_HSync delayed 2 cycles.
- o_VSync  out  1  i_VSync delayed 2 cycles.
- o_Col_Count  out  $clog2(TOTAL_COLS)  regenerated column.
- o_Row_Count  out  $clog2(TOTAL_ROWS)  regenerated row.
- o_Locked  out  1  high in LOCKED state.
- o_Sync_Err  out  1  one-cycle pulse on timing mismatch.
- o_Frame_Start  out  1  one-cycle pulse with row 0 / col 0.

## Operation
- **Input stage.** Register i_HSync/i_VSync into r_HS/r_VS, then into r_HS_d/r_VS_d.
  - H edge: r_HS & ~r_HS_d.
  - V edge: r_VS & ~r_VS_d.
  - o_HSync/o_VSync are r_HS/r_VS registered once more.
- **Column counter.**
  - On H edge: next value 0.
  - Otherwise: increment, wrapping from TOTAL_COLS-1 to 0.
- **Row counter.**
  - On V edge: next value 0. V edge has priority over H edge, since both coincide at frame start.
  - Else on H edge: increment, wrapping from TOTAL_ROWS-1 to 0.
  - Otherwise: hold.
- **o_Frame_Start.** Registered V edge, so it is high in the cycle the counts first read 0/0.
- **Column check**, per cycle, evaluated on current (pre-update) counts:
  - Error if an H edge occurs with col != TOTAL_COLS-1 (line too short).
  - Error if col == TOTAL_COLS-1 with no H edge (line too long or HSync lost).
- **Row check:**
  - Error if a V edge occurs unless row == TOTAL_ROWS-1 and an H edge is present.
  - Error if row == TOTAL_ROWS-1 and an H edge occurs without a V edge.
- **Lock FSM** with states SEARCH, ALIGN, LOCKED:
  - SEARCH: checks ignored, counters run as above, o_Locked=0. Go to ALIGN on V edge.
  - ALIGN: checks active. Any error keeps ALIGN, pulses o_Sync_Err and clears the clean-frame flag. Go to LOCKED on a V edge that has no error in that cycle and follows a full frame with no errors since entering ALIGN or since the last V edge.
  - LOCKED: o_Locked=1. Any error goes to ALIGN and pulses o_Sync_Err.
  - o_Sync_Err is never asserted in SEARCH.
- **Resync.** Counters always resync to the observed edges, even on error. After a mismatch, counts track the actual input immediately; only the lock status degrades.

## Timing
- **Reset (asynchronous, i_Rst_L=0).** All pipeline registers, counts, o_HSync, o_VSync, o_Locked, o_Sync_Err and o_Frame_Start are 0; state is SEARCH.
- **Reset release.** The first H/V edge can be detected at the earliest 2 cycles after the first sampled high input.
- **Latency.** 2 cycles from input to o_HSync/o_VSync. o_Col_Count=0 is in the same cycle as the first high o_HSync of a line.
- **o_Locked** rises in the cycle o_Frame_Start is high for the second clean frame boundary, i.e. with counts 0/0.
- **o_Sync_Err** is registered: it appears 1 cycle after the offending edge is detected, coincident with the resynced count. o_Locked falls in that same cycle.
- **Reset mid-frame.** Returns to SEARCH; a full clean frame is needed again to lock.

## Test plan
- TOTAL_COLS=10, TOTAL_ROWS=6, ACTIVE 8/4, ideal generator stimulus -> o_Locked rises at the start of the 2nd frame; from then o_Col_Count/o_Row_Count equal the generator counts delayed 2 cycles, o_Sync_Err never pulses, and o_Frame_Start pulses every 60 cycles.
- Same setup, one line shortened to 9 clocks after lock -> o_Sync_Err single pulse and o_Locked drops in the same cycle. o_Col_Count=0 aligns to the early edge. Relock at the frame start after the next clean frame.
- HSync held low for one whole line while locked -> error at col=9 with no edge, o_Locked=0, counters keep wrapping 0..9.
- VSync rising at row 3 -> error pulse, row resyncs to 0, o_Frame_Start pulses, state ALIGN.
- Assert i_Rst_L=0 mid-frame while locked -> all outputs 0 asynchronously; after release, no o_Sync_Err before the first V edge.
- Default params, 3 ideal frames -> lock at frame 2 start; col counts 0..799 and row counts 0..524 with no error.
